// File: rtl/mem_d_periph.sv
// Peripheral responder on the mem_d data port: GPIO out/in, free-running timer with compare,
// and a sticky match flag on irq_o. Side effects and read sampling happen in the accept cycle.
module mem_d_periph #(
    parameter logic [31:0] BASE_ADDR   = 32'h9000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TAG_W       = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      mem_d_addr_i,
    input  logic [31:0]      mem_d_data_wr_i,
    input  logic             mem_d_rd_i,
    input  logic [3:0]       mem_d_wr_i,
    input  logic             mem_d_cacheable_i,
    input  logic [TAG_W-1:0] mem_d_req_tag_i,
    input  logic             mem_d_invalidate_i,
    input  logic             mem_d_writeback_i,
    input  logic             mem_d_flush_i,
    input  logic [7:0]       gpio_pin_in_i,
    output logic [31:0]      mem_d_data_rd_o,
    output logic             mem_d_accept_o,
    output logic             mem_d_ack_o,
    output logic             mem_d_error_o,
    output logic [TAG_W-1:0] mem_d_resp_tag_o,
    output logic [7:0]       gpio_pin_out_o,
    output logic             irq_o
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic             r_ack;
    logic             r_err;
    logic [31:0]      r_rdata;
    logic [TAG_W-1:0] r_tag;
    logic [7:0]       r_gpio_out;
    logic [7:0]       r_gpio_meta;
    logic [7:0]       r_gpio_sync;
    logic [31:0]      r_timer;
    logic [31:0]      r_cmp;
    logic             r_match;

    logic        w_cop;
    logic        w_is_wr;
    logic        w_req;
    logic        w_take;
    logic        w_hit;
    logic [5:0]  w_idx;
    logic        w_mapped;
    logic        w_ok;
    logic        w_wr_en;
    logic [31:0] w_rdata;
    logic [31:0] w_timer_d;
    logic [31:0] w_cmp_d;
    logic [7:0]  w_gpio_d;
    logic        w_set;
    logic        w_clr;
    logic        w_unused;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    assign w_unused = ^{mem_d_cacheable_i, mem_d_addr_i[1:0]};

    // Cache ops outrank rd/wr and never touch registers.
    assign w_cop    = mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
    assign w_is_wr  = |mem_d_wr_i;
    assign w_req    = mem_d_rd_i | w_is_wr | w_cop;
    assign mem_d_accept_o = (r_state == StIdle) & ~rst_i;
    assign w_take   = w_req & mem_d_accept_o;
    assign w_hit    = mem_d_addr_i[31:8] == BASE_ADDR[31:8];
    assign w_idx    = mem_d_addr_i[7:2];
    assign w_mapped = w_idx <= 6'd4;
    assign w_ok     = w_hit & w_mapped & ~w_cop;
    assign w_wr_en  = w_take & w_ok & w_is_wr;

    always_comb begin
        w_rdata = 32'h0;
        case (w_idx)
            6'd0:    w_rdata = {24'h0, r_gpio_out};
            6'd1:    w_rdata = {24'h0, r_gpio_sync};
            6'd2:    w_rdata = r_timer;
            6'd3:    w_rdata = r_cmp;
            6'd4:    w_rdata = {31'h0, r_match};
            default: w_rdata = 32'h0;
        endcase
    end

    assign w_timer_d = (w_wr_en && w_idx == 6'd2) ?
                       merge_bytes(r_timer, mem_d_data_wr_i, mem_d_wr_i) : r_timer + 32'd1;
    assign w_cmp_d   = (w_wr_en && w_idx == 6'd3) ?
                       merge_bytes(r_cmp, mem_d_data_wr_i, mem_d_wr_i) : r_cmp;
    assign w_gpio_d  = (w_wr_en && w_idx == 6'd0 && mem_d_wr_i[0]) ?
                       mem_d_data_wr_i[7:0] : r_gpio_out;
    assign w_clr     = w_wr_en && w_idx == 6'd4 && mem_d_wr_i[0] && mem_d_data_wr_i[0];
    assign w_set     = (w_timer_d == w_cmp_d) && (w_cmp_d != 32'h0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gpio_out  <= 8'h0;
            r_gpio_meta <= 8'h0;
            r_gpio_sync <= 8'h0;
            r_timer     <= 32'h0;
            r_cmp       <= 32'h0;
            r_match     <= 1'b0;
        end else begin
            r_gpio_out  <= w_gpio_d;
            r_gpio_meta <= gpio_pin_in_i;
            r_gpio_sync <= r_gpio_meta;
            r_timer     <= w_timer_d;
            r_cmp       <= w_cmp_d;
            // A match in the same cycle as a clear keeps the flag set.
            r_match     <= w_set | (r_match & ~w_clr);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_cnt   <= 3'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'h0;
            r_tag   <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_take) begin
                        r_tag   <= mem_d_req_tag_i;
                        r_rdata <= w_ok ? w_rdata : 32'h0;
                        r_err   <= ~w_cop & ~(w_hit & w_mapped);
                        if (WAIT_STATES == 0) begin
                            r_state <= StResp;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= StWait;
                            r_cnt   <= 3'(WAIT_STATES - 1);
                        end
                    end
                end
                StWait: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= StResp;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                StResp:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign mem_d_ack_o      = r_ack;
    assign mem_d_error_o    = r_err;
    assign mem_d_data_rd_o  = r_rdata;
    assign mem_d_resp_tag_o = r_tag;
    assign gpio_pin_out_o   = r_gpio_out;
    assign irq_o            = r_match;

endmodule

// File: tb/tb_mem_d_periph.sv
// Bench for mem_d_periph: three instances (0, 3 and 5 wait states) on a shared request bus,
// directed scenarios plus randomized traffic against a register-level reference model.
module tb_mem_d_periph;

    localparam int TW = 11;
    localparam logic [31:0] BASE = 32'h9000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   d_addr, d_wdata;
    logic          d_rd, d_cache, d_inv, d_wb, d_fl;
    logic [3:0]    d_wr;
    logic [TW-1:0] d_tag;
    logic [7:0]    gpio_in;

    logic [31:0]   rd0, rd3, rd5;
    logic          acc0, acc3, acc5, ack0, ack3, ack5, err0, err3, err5, irq0, irq3, irq5;
    logic [TW-1:0] tag0, tag3, tag5;
    logic [7:0]    gpo0, gpo3, gpo5;

    int            sel;
    logic [31:0]   rdat;
    logic          acc, ack, errv, irq;
    logic [TW-1:0] rtagv;
    logic [7:0]    gpo;

    int unsigned   cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    // Reference model state: timer value is m_tval at cycle count m_tbase, advancing by one per cycle.
    logic [7:0]    m_gpio_out;
    logic [31:0]   m_cmp;
    logic [31:0]   m_tval;
    int unsigned   m_tbase;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_d_periph #(.BASE_ADDR(BASE), .WAIT_STATES(0), .TAG_W(TW)) u_ws0 (
        .clk_i(clk), .rst_i(rst), .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata),
        .mem_d_rd_i(d_rd), .mem_d_wr_i(d_wr), .mem_d_cacheable_i(d_cache),
        .mem_d_req_tag_i(d_tag), .mem_d_invalidate_i(d_inv), .mem_d_writeback_i(d_wb),
        .mem_d_flush_i(d_fl), .gpio_pin_in_i(gpio_in), .mem_d_data_rd_o(rd0),
        .mem_d_accept_o(acc0), .mem_d_ack_o(ack0), .mem_d_error_o(err0),
        .mem_d_resp_tag_o(tag0), .gpio_pin_out_o(gpo0), .irq_o(irq0));

    mem_d_periph #(.BASE_ADDR(BASE), .WAIT_STATES(3), .TAG_W(TW)) u_ws3 (
        .clk_i(clk), .rst_i(rst), .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata),
        .mem_d_rd_i(d_rd), .mem_d_wr_i(d_wr), .mem_d_cacheable_i(d_cache),
        .mem_d_req_tag_i(d_tag), .mem_d_invalidate_i(d_inv), .mem_d_writeback_i(d_wb),
        .mem_d_flush_i(d_fl), .gpio_pin_in_i(gpio_in), .mem_d_data_rd_o(rd3),
        .mem_d_accept_o(acc3), .mem_d_ack_o(ack3), .mem_d_error_o(err3),
        .mem_d_resp_tag_o(tag3), .gpio_pin_out_o(gpo3), .irq_o(irq3));

    mem_d_periph #(.BASE_ADDR(BASE), .WAIT_STATES(5), .TAG_W(TW)) u_ws5 (
        .clk_i(clk), .rst_i(rst), .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata),
        .mem_d_rd_i(d_rd), .mem_d_wr_i(d_wr), .mem_d_cacheable_i(d_cache),
        .mem_d_req_tag_i(d_tag), .mem_d_invalidate_i(d_inv), .mem_d_writeback_i(d_wb),
        .mem_d_flush_i(d_fl), .gpio_pin_in_i(gpio_in), .mem_d_data_rd_o(rd5),
        .mem_d_accept_o(acc5), .mem_d_ack_o(ack5), .mem_d_error_o(err5),
        .mem_d_resp_tag_o(tag5), .gpio_pin_out_o(gpo5), .irq_o(irq5));

    always_comb begin
        {rdat, acc, ack, errv, rtagv, gpo, irq} = {rd0, acc0, ack0, err0, tag0, gpo0, irq0};
        if (sel == 1) {rdat, acc, ack, errv, rtagv, gpo, irq} = {rd3, acc3, ack3, err3, tag3, gpo3, irq3};
        if (sel == 2) {rdat, acc, ack, errv, rtagv, gpo, irq} = {rd5, acc5, ack5, err5, tag5, gpo5, irq5};
    end

    task automatic clear_req();
        d_rd = 1'b0; d_wr = 4'h0; d_inv = 1'b0; d_wb = 1'b0; d_fl = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_tag = '0; d_cache = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_req();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_gpio_out = 8'h0; m_cmp = 32'h0; m_tval = 32'h0; m_tbase = cyc;
    endtask

    // Presents one request, holds it until accepted, then waits for the ack (returns on the ack cycle).
    task automatic txn(input logic rd, input logic [3:0] wr, input logic [2:0] cop,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [TW-1:0] tag,
                       output logic [31:0] data, output logic err, output logic [TW-1:0] rtag,
                       output int unsigned acc_cyc, output int lat);
        int n;
        @(negedge clk);
        d_rd = rd; d_wr = wr; {d_inv, d_wb, d_fl} = cop; d_addr = addr; d_wdata = wdata;
        d_tag = tag; d_cache = 1'($urandom_range(0, 1));
        n = 0;
        while (acc !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        acc_cyc = cyc;
        @(negedge clk);
        clear_req();
        lat = 1;
        while (ack !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        data = rdat; err = errv; rtag = rtagv;
        n_cmp++;
        if (ack !== 1'b1) begin
            n_bad++;
            $display("FAIL handshake addr=%h got no ack within bound (acc=%b)", addr, acc);
        end
    endtask

    task automatic test_reset();
        logic [54:0] v;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            v = {acc, ack, rdat, errv, rtagv, gpo, irq};
            n_cmp++;
            if (v !== '0) begin n_bad++; $display("FAIL reset_outputs inst%0d got %h want 0", s, v); end
        end
        rst = 1'b0;
        m_tbase = cyc;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            n_cmp++;
            if (acc !== 1'b1) begin n_bad++; $display("FAIL reset_accept inst%0d got %b want 1", s, acc); end
        end
    endtask

    task automatic test_gpio_out();
        logic [31:0] d; logic e; logic [TW-1:0] t, tg; int unsigned a; int lat;
        sel = 0; do_reset();
        tg = TW'($urandom);
        txn(1'b0, 4'b0001, 3'b000, BASE, 32'h0000_00A5, tg, d, e, t, a, lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL gpio_wr_latency got %0d want 1", lat); end
        n_cmp++; if (t !== tg) begin n_bad++; $display("FAIL gpio_wr_tag got %h want %h", t, tg); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL gpio_wr_err got %b want 0", e); end
        n_cmp++; if (gpo !== 8'hA5) begin n_bad++; $display("FAIL gpio_out_pins got %h want a5", gpo); end
        txn(1'b0, 4'b1110, 3'b000, BASE, 32'hFFFF_FF5A, tg, d, e, t, a, lat);
        n_cmp++; if (gpo !== 8'hA5) begin n_bad++; $display("FAIL gpio_strb_ignored got %h want a5", gpo); end
        txn(1'b1, 4'b0000, 3'b000, BASE, 32'h0, tg, d, e, t, a, lat);
        n_cmp++; if (d !== 32'hA5) begin n_bad++; $display("FAIL gpio_out_read got %h want a5", d); end
    endtask

    task automatic test_gpio_in();
        logic [31:0] d; logic e; logic [TW-1:0] t; int unsigned a; int lat;
        sel = 0;
        gpio_in = 8'h3C;
        repeat (4) @(negedge clk);
        txn(1'b1, 4'b0000, 3'b000, BASE + 32'h4, 32'h0, TW'(1), d, e, t, a, lat);
        n_cmp++; if (d !== 32'h3C) begin n_bad++; $display("FAIL gpio_in_read got %h want 3c", d); end
        gpio_in = 8'h5A;
        txn(1'b1, 4'b0000, 3'b000, BASE + 32'h4, 32'h0, TW'(2), d, e, t, a, lat);
        n_cmp++; if (d !== 32'h3C) begin n_bad++; $display("FAIL gpio_in_sync_delay got %h want 3c", d); end
        repeat (3) @(negedge clk);
        txn(1'b1, 4'b0001, 3'b000, BASE + 32'h4, 32'hFF, TW'(3), d, e, t, a, lat);
        n_cmp++; if (d !== 32'h5A || e !== 1'b0) begin
            n_bad++; $display("FAIL gpio_in_new got %h err %b want 5a err 0", d, e);
        end
    endtask

    task automatic test_timer_match();
        logic [31:0] d; logic e; logic [TW-1:0] t; int unsigned a, a2; int lat;
        sel = 0; do_reset();
        txn(1'b0, 4'hF, 3'b000, BASE + 32'hC, 32'h0000_0001, TW'(4), d, e, t, a, lat);
        txn(1'b0, 4'hF, 3'b000, BASE + 32'h8, 32'hFFFF_FFFE, TW'(5), d, e, t, a, lat);
        // Timer reads FFFF_FFFE, FFFF_FFFF, 0, 1 on the cycles after the write.
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            n_cmp++;
            if (irq !== (k == 4)) begin
                n_bad++; $display("FAIL irq_on_match step%0d got %b want %b", k, irq, k == 4);
            end
        end
        txn(1'b1, 4'h0, 3'b000, BASE + 32'h8, 32'h0, TW'(6), d, e, t, a2, lat);
        n_cmp++; if (d !== 32'hFFFF_FFFE + 32'(a2 - (a + 1))) begin
            n_bad++; $display("FAIL timer_wrap got %h want %h", d, 32'hFFFF_FFFE + 32'(a2 - (a + 1)));
        end
        txn(1'b1, 4'h0, 3'b000, BASE + 32'h10, 32'h0, TW'(7), d, e, t, a, lat);
        n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL status_read got %h want 1", d); end
        txn(1'b0, 4'b0001, 3'b000, BASE + 32'h10, 32'h1, TW'(8), d, e, t, a, lat);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL match_clear got %b want 0", irq); end
        // Timer reaches 1 exactly at the edge ending the status-clear accept cycle.
        txn(1'b0, 4'hF, 3'b000, BASE + 32'h8, 32'hFFFF_FFFF, TW'(9), d, e, t, a, lat);
        txn(1'b0, 4'b0001, 3'b000, BASE + 32'h10, 32'h1, TW'(10), d, e, t, a2, lat);
        n_cmp++; if (a2 !== a + 2) begin
            n_bad++; $display("FAIL back_to_back_accept got cycle %0d want %0d", a2, a + 2);
        end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL set_beats_clear got %b want 1", irq); end
    endtask

    task automatic test_wait_states();
        logic [31:0] d, v; logic e; logic [TW-1:0] t; int unsigned a; int lat;
        logic exp_acc, exp_ack;
        sel = 1; do_reset();
        v = $urandom;
        txn(1'b0, 4'hF, 3'b000, BASE + 32'hC, v, TW'(1), d, e, t, a, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ws3_latency got %0d want 4", lat); end
        @(negedge clk);
        d_rd = 1'b1; d_addr = BASE + 32'hC; d_tag = TW'(11'h155);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL ws3_first_accept got %b want 1", acc); end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin d_addr = BASE; d_tag = TW'(11'h2AA); end
            if (k == 6) clear_req();
            exp_acc = (k == 5);
            exp_ack = (k == 4) || (k == 9);
            n_cmp++;
            if (acc !== exp_acc || ack !== exp_ack) begin
                n_bad++;
                $display("FAIL ws3_cycle%0d got acc %b ack %b want acc %b ack %b",
                         k, acc, ack, exp_acc, exp_ack);
            end
            if (k == 4) begin
                n_cmp++;
                if (rtagv !== TW'(11'h155) || rdat !== v || errv !== 1'b0) begin
                    n_bad++; $display("FAIL ws3_resp1 got tag %h data %h err %b want 155 %h 0",
                                      rtagv, rdat, errv, v);
                end
            end
            if (k == 9) begin
                n_cmp++;
                if (rtagv !== TW'(11'h2AA) || rdat !== 32'h0) begin
                    n_bad++; $display("FAIL ws3_resp2 got tag %h data %h want 2aa 0", rtagv, rdat);
                end
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] d, v; logic e; logic [TW-1:0] t; int unsigned a; int lat;
        sel = 0; do_reset();
        v = $urandom | 32'h1;
        txn(1'b0, 4'h1, 3'b000, BASE, 32'hA5, TW'(1), d, e, t, a, lat);
        txn(1'b0, 4'hF, 3'b000, BASE + 32'hC, v, TW'(2), d, e, t, a, lat);
        txn(1'b1, 4'h0, 3'b000, BASE + 32'h40, 32'h0, TW'(3), d, e, t, a, lat);
        n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin
            n_bad++; $display("FAIL unmapped_read got err %b data %h want 1 0", e, d);
        end
        txn(1'b1, 4'h0, 3'b000, 32'h1000_0000, 32'h0, TW'(4), d, e, t, a, lat);
        n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin
            n_bad++; $display("FAIL miss_read got err %b data %h want 1 0", e, d);
        end
        txn(1'b0, 4'hF, 3'b000, BASE + 32'h40, $urandom, TW'(5), d, e, t, a, lat);
        txn(1'b0, 4'h1, 3'b000, 32'h1000_0000, 32'h11, TW'(6), d, e, t, a, lat);
        txn(1'b0, 4'h1, 3'b001, BASE, 32'h22, TW'(7), d, e, t, a, lat);
        n_cmp++; if (e !== 1'b0 || d !== 32'h0) begin
            n_bad++; $display("FAIL cache_op got err %b data %h want 0 0", e, d);
        end
        n_cmp++; if (gpo !== 8'hA5) begin n_bad++; $display("FAIL no_side_effect_gpio got %h want a5", gpo); end
        txn(1'b1, 4'h0, 3'b000, BASE + 32'hC, 32'h0, TW'(8), d, e, t, a, lat);
        n_cmp++; if (d !== v) begin n_bad++; $display("FAIL no_side_effect_cmp got %h want %h", d, v); end
        txn(1'b1, 4'h1, 3'b000, BASE, 32'h3C, TW'(9), d, e, t, a, lat);
        n_cmp++; if (d !== 32'hA5 || gpo !== 8'h3C) begin
            n_bad++; $display("FAIL rd_wr_combined got data %h pins %h want a5 3c", d, gpo);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e; logic [TW-1:0] t; int unsigned a; int lat;
        logic [54:0] v; logic saw;
        sel = 2; do_reset();
        @(negedge clk);
        d_rd = 1'b1; d_addr = BASE; d_tag = TW'(7);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL ws5_accept got %b want 1", acc); end
        @(negedge clk);
        clear_req();
        @(negedge clk);
        rst = 1'b1;
        #1;
        v = {acc, ack, rdat, errv, rtagv, gpo, irq};
        n_cmp++; if (v !== '0) begin n_bad++; $display("FAIL midreset_outputs got %h want 0", v); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ack === 1'b1) saw = 1'b1;
        end
        n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL midreset_no_ack got ack %b want 0", saw); end
        txn(1'b1, 4'h0, 3'b000, BASE, 32'h0, TW'(3), d, e, t, a, lat);
        n_cmp++; if (lat !== 6 || t !== TW'(3) || e !== 1'b0) begin
            n_bad++; $display("FAIL midreset_recover got lat %0d tag %h err %b want 6 003 0", lat, t, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, addr, wd, cur, exp_d, nv; logic e, exp_e, hit, rd; logic [3:0] wr;
        logic [2:0] cop; logic [7:0] off; logic [TW-1:0] t, tg; int unsigned a; int lat;
        logic [7:0] offs [6];
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h40, 8'h14};
        sel = 0; do_reset();
        for (int i = 0; i < 60; i++) begin
            gpio_in = 8'($urandom);
            repeat (2) @(negedge clk);
            off  = offs[$urandom_range(0, 5)];
            hit  = $urandom_range(0, 7) != 0;
            addr = (hit ? BASE : 32'h1000_0000) | {24'h0, off} | 32'($urandom_range(0, 3));
            cop  = ($urandom_range(0, 7) == 0) ? (3'b001 << $urandom_range(0, 2)) : 3'b000;
            rd   = 1'($urandom_range(0, 1));
            wr   = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            if (!rd && wr == 4'h0) rd = 1'b1;
            wd   = $urandom;
            tg   = TW'($urandom);
            txn(rd, wr, cop, addr, wd, tg, d, e, t, a, lat);
            exp_d = 32'h0; exp_e = 1'b0;
            if (cop == 3'b000) begin
                if (!hit || off > 8'h0C) begin
                    exp_e = 1'b1;
                end else begin
                    case (off)
                        8'h00:   cur = {24'h0, m_gpio_out};
                        8'h04:   cur = {24'h0, gpio_in};
                        8'h08:   cur = m_tval + 32'(a - m_tbase);
                        default: cur = m_cmp;
                    endcase
                    exp_d = cur;
                    nv = cur;
                    for (int b = 0; b < 4; b++) if (wr[b]) nv[8*b +: 8] = wd[8*b +: 8];
                    if (wr != 4'h0) begin
                        if (off == 8'h00 && wr[0]) m_gpio_out = wd[7:0];
                        if (off == 8'h08) begin m_tval = nv; m_tbase = a + 1; end
                        if (off == 8'h0C) m_cmp = nv;
                    end
                end
            end
            n_cmp++;
            if (e !== exp_e || t !== tg || ((rd || exp_e || cop != 3'b000) && d !== exp_d)) begin
                n_bad++;
                $display("FAIL random%0d addr %h rd %b wr %h cop %b got d %h e %b t %h want d %h e %b t %h",
                         i, addr, rd, wr, cop, d, e, t, exp_d, exp_e, tg);
            end
            n_cmp++;
            if (gpo !== m_gpio_out) begin
                n_bad++; $display("FAIL random%0d_pins got %h want %h", i, gpo, m_gpio_out);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sel = 0;
        gpio_in = 8'h0;
        clear_req();
        m_gpio_out = 8'h0; m_cmp = 32'h0; m_tval = 32'h0; m_tbase = 0;
        test_reset();
        test_gpio_out();
        test_gpio_in();
        test_timer_match();
        test_wait_states();
        test_errors();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_d_periph.md
Name: mem_d_periph

Overview:
- Memory-mapped peripheral responder on the core's data-memory port (mem_d request / accept / ack / tag protocol), the responding end opposite the core's data initiator.
- Provides GPIO output/input registers, a free-running 32-bit timer with compare, and a sticky match flag driving irq_o.
- Sits beside the TCM on the data bus; an upstream address decode steers peripheral-window requests here.

Parameters:
- BASE_ADDR, 32'h9000_0000, peripheral window base; window is BASE_ADDR[31:8] (256 bytes).
- WAIT_STATES, 0, extra cycles between accept and ack (0..7).
- TAG_W, 11, request/response tag width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- mem_d_addr_i  in  32  byte address
- mem_d_data_wr_i  in  32  write data
- mem_d_rd_i  in  1  read request
- mem_d_wr_i  in  4  byte write strobes
- mem_d_cacheable_i  in  1  ignored
- mem_d_req_tag_i  in  TAG_W  request tag
- mem_d_invalidate_i  in  1  cache-op request
- mem_d_writeback_i  in  1  cache-op request
- mem_d_flush_i  in  1  cache-op request
- gpio_pin_in_i  in  8  asynchronous GPIO inputs
- mem_d_data_rd_o  out  32  read data, valid with ack
- mem_d_accept_o  out  1  request accepted this cycle
- mem_d_ack_o  out  1  one-cycle response strobe
- mem_d_error_o  out  1  error flag, valid with ack
- mem_d_resp_tag_o  out  TAG_W  echoed tag, valid with ack
- gpio_pin_out_o  out  8  GPIO output register
- irq_o  out  1  timer-match interrupt (level)

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is asynchronous and active-high.
- Reset values: all outputs 0. GPIO_OUT, TIMER, CMP and MATCH are 0; synchronizer flops are 0; FSM is in IDLE.
- Request: req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i.
- Accept: mem_d_accept_o = 1 only in IDLE (combinational). A request is taken when req & accept.
- FSM states: IDLE, WAIT, RESP.
  - IDLE -> RESP when a request is taken and WAIT_STATES = 0.
  - IDLE -> WAIT when a request is taken and WAIT_STATES > 0; load a 3-bit counter with WAIT_STATES-1.
  - WAIT decrements the counter and moves to RESP at 0.
  - RESP drives ack = 1 for exactly one cycle with the latched tag, data and error, then returns to IDLE.
- Latency: ack follows accept after WAIT_STATES+1 cycles.
- Back-to-back requests: the earliest new accept is the cycle after ack, because the FSM is back in IDLE then.
- Latch on accept: tag, address, write data, strobes and request kind.
- Write side effects are applied in the accept cycle. Read data is sampled in the accept cycle.
- Decode: hit = addr[31:8] == BASE_ADDR[31:8]; register = addr[7:2].
  - 0x00 GPIO_OUT: RW. Only strobe bit 0 writes [7:0]; reads zero-extended.
  - 0x04 GPIO_IN: RO. Returns a 2-flop synchronised gpio_pin_in_i, zero-extended; writes are ignored with no error.
  - 0x08 TIMER: RW. Increments every cycle and wraps FFFF_FFFF -> 0. Byte strobes apply. A write in the same cycle as an increment wins (the written value is loaded, no increment that cycle).
  - 0x0C CMP: RW, byte strobes.
  - 0x10 STATUS: bit0 = MATCH. Write 1 to bit0 (strobe 0) clears it.
- MATCH: set in the cycle TIMER == CMP (after update), with CMP != 0. If set and clear occur in the same cycle, set wins. irq_o = MATCH.
- Errors: unmapped offset or !hit gives error = 1 and read data 0, with no side effects. Ack still occurs.
- Request with both rd and wr set: treated as a write. Read data returned = register value before the write.
- Cache-op requests (invalidate/writeback/flush): acked with error = 0, data 0, no side effects. They take priority over rd/wr if combined.
- Reset mid-transaction: FSM returns to IDLE and any pending ack is dropped, with no ack after reset release.
- No change to latched response fields while in WAIT or RESP.

Test Plan:
- Write 0x0000_00A5, strb 4'b0001, to BASE+0x00, WAIT_STATES=0 -> accept on cycle 0, ack on cycle 1 with tag echoed, error 0; gpio_pin_out_o = 8'hA5 from cycle 1.
- gpio_pin_in_i = 8'h3C held, read BASE+0x04 four cycles later -> ack data 0x0000_003C; with input changed one cycle before the read, old value returned (2-flop delay).
- Write TIMER = FFFF_FFFE, CMP = 0000_0001 -> TIMER wraps to 0 two cycles later; MATCH and irq_o assert when TIMER = 1; writing STATUS 0x1 clears them; a clear coinciding with a new match leaves MATCH = 1.
- WAIT_STATES=3, read BASE+0x0C tag 0x155 -> accept low for cycles 1..4, ack at cycle 4 with tag 0x155; a request presented at cycle 2 is not accepted until cycle 5.
- Read BASE+0x40 and read 0x1000_0000 -> ack with error 1, data 0; a write to BASE+0x40 changes no register.
- Assert rst_i during WAIT (WAIT_STATES=5) -> all outputs 0 immediately, no ack after release, next request is accepted normally.
